// File: rtl/snax_simbacore_pkg.sv
// Shared types and CSR address-map helpers for the SimbaCore CSR manager.
package snax_simbacore_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Offsets of each region relative to the RW/RO word counts.
  localparam int unsigned StartOffsetFromRw   = 1;
  localparam int unsigned RoBaseOffsetFromRw  = 0;
  localparam int unsigned CounterOffsetFromRo = 0;

  function automatic int unsigned start_addr(input int unsigned rw_count);
    return rw_count - StartOffsetFromRw;
  endfunction

  function automatic int unsigned ro_base_addr(input int unsigned rw_count);
    return rw_count + RoBaseOffsetFromRw;
  endfunction

  function automatic int unsigned counter_addr(input int unsigned rw_count,
                                               input int unsigned ro_count);
    return rw_count + ro_count + CounterOffsetFromRo;
  endfunction

endpackage

// File: rtl/snax_simbacore_csr_manager.sv
// CSR front-end for SimbaCore: config register file, launch FSM and read responses.
// Define SNAX_SIMBACORE_CYCLE_COUNTER_EN to add a readable RUN-cycle counter.
module snax_simbacore_csr_manager
  import snax_simbacore_pkg::*;
#(
  parameter int unsigned RegRWCount   = 6,
  parameter int unsigned RegROCount   = 2,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned RegAddrWidth = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [RegAddrWidth-1:0]                  csr_req_addr_i,
  input  logic [RegDataWidth-1:0]                  csr_req_data_i,
  input  logic                                     csr_req_wen_i,
  input  logic                                     csr_req_valid_i,
  output logic                                     csr_req_ready_o,
  output logic [RegDataWidth-1:0]                  csr_rsp_data_o,
  output logic                                     csr_rsp_valid_o,
  input  logic                                     csr_rsp_ready_i,
  output logic [RegRWCount-2:0][RegDataWidth-1:0]  csr_reg_set_o,
  output logic                                     csr_reg_set_valid_o,
  input  logic                                     csr_reg_set_ready_i,
  input  logic [RegROCount-1:0][RegDataWidth-1:0]  csr_reg_ro_set_i
);

  localparam int unsigned NumCfg = RegRWCount - 1;
  localparam logic [RegAddrWidth-1:0] StartAddr = RegAddrWidth'(start_addr(RegRWCount));

  state_e                               state_q, state_d;
  logic [NumCfg-1:0][RegDataWidth-1:0]  cfg_q, cfg_d;
  logic                                 set_valid_q, set_valid_d;
  logic                                 rsp_valid_q, rsp_valid_d;
  logic [RegDataWidth-1:0]              rsp_data_q, rsp_data_d;
  logic                                 run_first_q, run_first_d;
`ifdef SNAX_SIMBACORE_CYCLE_COUNTER_EN
  localparam logic [RegAddrWidth-1:0] CntAddr =
    RegAddrWidth'(counter_addr(RegRWCount, RegROCount));
  logic [RegDataWidth-1:0]              cnt_q, cnt_d;
`endif

  logic                    wr_hs, rd_hs, busy;
  logic [RegDataWidth-1:0] rd_data;

  assign csr_req_ready_o     = !rsp_valid_q || csr_rsp_ready_i;
  assign wr_hs               = csr_req_valid_i && csr_req_ready_o && csr_req_wen_i;
  assign rd_hs               = csr_req_valid_i && csr_req_ready_o && !csr_req_wen_i;
  assign busy                = csr_reg_ro_set_i[0][0];
  assign csr_rsp_valid_o     = rsp_valid_q;
  assign csr_rsp_data_o      = rsp_data_q;
  assign csr_reg_set_o       = cfg_q;
  assign csr_reg_set_valid_o = set_valid_q;

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NumCfg; i++) begin
      if (csr_req_addr_i == RegAddrWidth'(i)) rd_data = cfg_q[i];
    end
    if (csr_req_addr_i == StartAddr) rd_data = RegDataWidth'(state_q != IDLE);
    for (int unsigned i = 0; i < RegROCount; i++) begin
      if (csr_req_addr_i == RegAddrWidth'(ro_base_addr(RegRWCount) + i)) begin
        rd_data = csr_reg_ro_set_i[i];
      end
    end
`ifdef SNAX_SIMBACORE_CYCLE_COUNTER_EN
    if (csr_req_addr_i == CntAddr) rd_data = cnt_q;
`endif
  end

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    run_first_d = run_first_q;
`ifdef SNAX_SIMBACORE_CYCLE_COUNTER_EN
    cnt_d       = cnt_q;
`endif

    if (rsp_valid_q && csr_rsp_ready_i) rsp_valid_d = 1'b0;
    if (rd_hs) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rd_data;
    end

    // Config and start writes only land in IDLE; elsewhere they are handshaken and dropped.
    unique case (state_q)
      IDLE: begin
        if (wr_hs) begin
          for (int unsigned i = 0; i < NumCfg; i++) begin
            if (csr_req_addr_i == RegAddrWidth'(i)) cfg_d[i] = csr_req_data_i;
          end
          if (csr_req_addr_i == StartAddr && csr_req_data_i[0]) begin
            state_d = ISSUE;
`ifdef SNAX_SIMBACORE_CYCLE_COUNTER_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ISSUE: begin
        if (csr_reg_set_ready_i) begin
          state_d     = RUN;
          run_first_d = 1'b1;
        end
      end
      RUN: begin
        run_first_d = 1'b0;
`ifdef SNAX_SIMBACORE_CYCLE_COUNTER_EN
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`endif
        // Busy may lag the launch by a cycle, so the first RUN cycle never completes.
        if (!run_first_q && !busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    set_valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      set_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      run_first_q <= 1'b0;
`ifdef SNAX_SIMBACORE_CYCLE_COUNTER_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      set_valid_q <= set_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      run_first_q <= run_first_d;
`ifdef SNAX_SIMBACORE_CYCLE_COUNTER_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_snax_simbacore_csr_manager.sv
// Self-checking bench for snax_simbacore_csr_manager: behavioural model plus directed vectors.
// Works with or without SNAX_SIMBACORE_CYCLE_COUNTER_EN defined.
module tb_snax_simbacore_csr_manager;

  localparam int RW = 6;
  localparam int RO = 2;
  localparam int W  = 32;
  localparam int AW = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [AW-1:0]      req_addr = '0;
  logic [W-1:0]       req_data = '0;
  logic               req_wen = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [W-1:0]       rsp_data;
  logic               rsp_valid;
  logic               rsp_ready = 1'b1;
  logic [RW-2:0][W-1:0] set_words;
  logic               set_valid;
  logic               set_ready = 1'b1;
  logic [RO-1:0][W-1:0] ro = '0;

  always #5 clk = ~clk;

  snax_simbacore_csr_manager #(
    .RegRWCount  (RW),
    .RegROCount  (RO),
    .RegDataWidth(W),
    .RegAddrWidth(AW)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .csr_req_addr_i     (req_addr),
    .csr_req_data_i     (req_data),
    .csr_req_wen_i      (req_wen),
    .csr_req_valid_i    (req_valid),
    .csr_req_ready_o    (req_ready),
    .csr_rsp_data_o     (rsp_data),
    .csr_rsp_valid_o    (rsp_valid),
    .csr_rsp_ready_i    (rsp_ready),
    .csr_reg_set_o      (set_words),
    .csr_reg_set_valid_o(set_valid),
    .csr_reg_set_ready_i(set_ready),
    .csr_reg_ro_set_i   (ro)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 waiting for accelerator accept, 2 running.
  logic [W-1:0] m_cfg [RW-1];
  int           m_phase;
  int           m_run_n;
  logic         m_rsp_v;
  logic [W-1:0] m_rsp_d;
  logic [W-1:0] m_cnt;
  logic         m_ready;

  assign m_ready = !m_rsp_v || rsp_ready;

  function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
    if (a < RW - 1) return m_cfg[a[2:0]];
    if (a == RW - 1) return (m_phase != 0) ? 32'd1 : 32'd0;
    if (a == RW) return ro[0];
    if (a == RW + 1) return ro[1];
`ifdef SNAX_SIMBACORE_CYCLE_COUNTER_EN
    if (a == RW + RO) return m_cnt;
`endif
    return '0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RW - 1; i++) m_cfg[i] <= '0;
      m_phase <= 0;
      m_run_n <= 0;
      m_rsp_v <= 1'b0;
      m_rsp_d <= '0;
      m_cnt   <= '0;
    end else begin
      if (m_rsp_v && rsp_ready) m_rsp_v <= 1'b0;
      if (req_valid && m_ready && !req_wen) begin
        m_rsp_v <= 1'b1;
        m_rsp_d <= m_read(req_addr);
      end
      case (m_phase)
        0: if (req_valid && m_ready && req_wen) begin
             if (req_addr < RW - 1) m_cfg[req_addr[2:0]] <= req_data;
             if (req_addr == RW - 1 && req_data[0]) begin
               m_phase <= 1;
               m_cnt   <= '0;
             end
           end
        1: if (set_ready) begin
             m_phase <= 2;
             m_run_n <= 1;
           end
        default: begin
          m_run_n <= m_run_n + 1;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 1;
          if (m_run_n >= 2 && !ro[0][0]) m_phase <= 0;
        end
      endcase
    end
  end

  // Compare every cycle, late in the high phase when everything is settled.
  always @(posedge clk) begin
    #4;
    if (chk_en) begin
      check("req_ready", {31'd0, req_ready}, {31'd0, m_ready});
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rsp_v});
      if (m_rsp_v) check("rsp_data", rsp_data, m_rsp_d);
      check("set_valid", {31'd0, set_valid}, (m_phase == 1) ? 32'd1 : 32'd0);
      for (int i = 0; i < RW - 1; i++) check("set_word", set_words[i], m_cfg[i]);
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    req_addr = a; req_data = d; req_wen = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; req_wen = 1'b0;
  endtask

  task automatic rd(input string name, input logic [AW-1:0] a, input logic [W-1:0] exp);
    @(negedge clk);
    req_addr = a; req_wen = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check(name, rsp_data, exp);
  endtask

  logic [W-1:0] cnt_exp;

  initial begin
    // Reset with the accelerator ready: nothing may launch, every address reads 0.
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_set_valid", {31'd0, set_valid}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    for (int a = 0; a < RW + RO + 1; a++) rd("rst_read", a, 32'd0);

    // Launch with accelerator backpressure for three cycles.
    ro[1] = 32'hA5A5_0000;
    ro[0] = 32'd1;
    set_ready = 1'b0;
    wr(0, 1); wr(1, 16); wr(2, 64); wr(3, 4); wr(4, 128);
    wr(RW - 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("issue_valid", {31'd0, set_valid}, 32'd1);
      check("issue_word0", set_words[0], 32'd1);
      check("issue_word1", set_words[1], 32'd16);
      check("issue_word4", set_words[4], 32'd128);
    end
    @(negedge clk);
    check("issue_valid_c4", {31'd0, set_valid}, 32'd1);
    set_ready = 1'b1;
    @(posedge clk);
    // Busy stays high for the first ten RUN edges; completion lands on the eleventh,
    // so the cycle counter ends at 11.
    fork
      begin
        repeat (10) @(posedge clk);
        #1 ro[0] = 32'd0;
      end
    join_none
    rd("run_start", RW - 1, 32'd1);

    // Lockout: writes during RUN are acknowledged but dropped.
    wr(0, 7);
    wr(RW - 1, 1);
    rd("lock_word0", 0, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_relaunch", {31'd0, set_valid}, 32'd0);
    end
    rd("done_start", RW - 1, 32'd0);
`ifdef SNAX_SIMBACORE_CYCLE_COUNTER_EN
    cnt_exp = 32'd11;
`else
    cnt_exp = 32'd0;
`endif
    rd("cycle_counter", RW + RO, cnt_exp);

    // Start with bit 0 clear is ignored.
    wr(RW - 1, 2);
    rd("start_bit0_clear", RW - 1, 32'd0);

    // Response backpressure: first response held, second request stalled.
    @(negedge clk);
    rsp_ready = 1'b0; req_addr = 1; req_wen = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_addr = 2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check("bp_rsp_data", rsp_data, 32'd16);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("bp_second_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_second_data", rsp_data, 32'd64);

    // Unmapped and read-only addresses.
    rd("unmapped_read", 100, 32'd0);
    ro[0] = 32'h1234_5670;
    wr(RW, 32'hFFFF_FFFF);
    rd("ro_word0", RW, 32'h1234_5670);
    rd("ro_word1", RW + 1, 32'hA5A5_0000);
    wr(3, 9);
    rd("write_then_read", 3, 32'd9);

    // Asynchronous reset while ISSUE is pending and a response is outstanding.
    set_ready = 1'b0;
    wr(RW - 1, 1);
    @(negedge clk);
    check("pre_rst_valid", {31'd0, set_valid}, 32'd1);
    rsp_ready = 1'b0; req_addr = 0; req_wen = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2;
    check("pre_rst_rsp", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_set_valid", {31'd0, set_valid}, 32'd0);
    check("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("async_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    rst = 1'b0; rsp_ready = 1'b1; set_ready = 1'b1;
    rd("post_rst_word0", 0, 32'd0);
    rd("post_rst_start", RW - 1, 32'd0);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
